// File: rtl/axis_pin_pkg.sv
// Shared widths, FIFO entry layout and serialiser state encoding for the
// AXI4-Stream <-> pin-bus blocks (sink and source).
package axis_pin_pkg;

    localparam int AXIS_DATA_W = 32;
    localparam int AXIS_KEEP_W = 4;
    localparam int PIN_W       = 8;

    // Word FIFO entry: {tlast, tkeep, tdata}
    localparam int ENTRY_W        = AXIS_DATA_W + AXIS_KEEP_W + 1;
    localparam int ENTRY_DATA_LSB = 0;
    localparam int ENTRY_KEEP_LSB = AXIS_DATA_W;
    localparam int ENTRY_LAST_BIT = AXIS_DATA_W + AXIS_KEEP_W;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

    // True when the lane being presented closes the frame: the highest kept
    // lane of a tlast word, or lane 3 when the tlast word keeps nothing.
    function automatic logic lane_marks_frame_end(
        input logic [AXIS_KEEP_W-1:0] keep,
        input logic [1:0]             lane,
        input logic                   last
    );
        logic higher_kept;
        higher_kept = 1'b0;
        for (int i = 0; i < AXIS_KEEP_W; i++) begin
            if (i > int'(lane) && keep[i]) higher_kept = 1'b1;
        end
        if (!last) return 1'b0;
        if (keep[lane]) return !higher_kept;
        return (lane == 2'd3) && (keep == '0);
    endfunction

endpackage

// File: rtl/axis_word_fifo.sv
// Synchronous word FIFO with asynchronous active-low reset. Head is read
// combinationally; the caller must never pop when empty or push when full.
module axis_word_fifo #(
    parameter int WIDTH      = 37,
    parameter int DEPTH_BITS = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_push,
    input  logic [WIDTH-1:0]      i_din,
    input  logic                  i_pop,
    output logic [WIDTH-1:0]      o_head,
    output logic [DEPTH_BITS:0]   o_count,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int CW = DEPTH_BITS + 1;
    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_BITS-1:0] r_wr_ptr;
    logic [DEPTH_BITS-1:0] r_rd_ptr;
    logic [DEPTH_BITS:0]   r_count;

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_din;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == FULL_COUNT);
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/axi_stream_pin_sink.sv
// AXI4-Stream slave that buffers 32-bit words and serialises them LSB lane
// first onto an 8-bit pin bus. Optional AXIS_PIN_SINK_UNDERRUN_CNT_EN adds
// a saturating mid-frame starvation counter (underrun_count).
module axi_stream_pin_sink
    import axis_pin_pkg::*;
#(
    parameter int FIFO_DEPTH_BITS = 4,
    parameter int CLK_DIV         = 1
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic [AXIS_DATA_W-1:0] s_axis_tdata,
    input  logic [AXIS_KEEP_W-1:0] s_axis_tkeep,
    input  logic                   s_axis_tlast,
    output logic [PIN_W-1:0]       data_pins,
    output logic                   pins_valid,
    output logic                   frame_end,
`ifdef AXIS_PIN_SINK_UNDERRUN_CNT_EN
    output logic [15:0]            underrun_count,
`endif
    output ser_state_e             o_dbg_state
);

    localparam int CW = FIFO_DEPTH_BITS + 1;
    localparam logic [FIFO_DEPTH_BITS:0] FULL_COUNT  = CW'(1 << FIFO_DEPTH_BITS);
    localparam logic [7:0]               SLOT_RELOAD = 8'(CLK_DIV - 1);

    ser_state_e             r_state, w_state_next;
    logic [AXIS_DATA_W-1:0] r_shift, w_shift_next;
    logic [AXIS_KEEP_W-1:0] r_keep, w_keep_next;
    logic                   r_last, w_last_next;
    logic [1:0]             r_lane, w_lane_next;
    logic [7:0]             r_slot, w_slot_next;
    logic [PIN_W-1:0]       r_data_pins, w_data_pins_next;
    logic                   r_pins_valid, w_pins_valid_next;
    logic                   r_frame_end, w_frame_end_next;
    logic                   r_tready;

    logic                   w_push, w_pop, w_full, w_empty;
    logic                   w_lane_done, w_advance;
    logic [ENTRY_W-1:0]     w_din, w_head;
    logic [FIFO_DEPTH_BITS:0] w_count, w_count_next;

    logic [AXIS_KEEP_W-1:0] w_ent_keep;
    logic [1:0]             w_ent_lane;
    logic                   w_ent_last;
    logic [PIN_W-1:0]       w_ent_byte;
    logic [AXIS_DATA_W-1:0] w_ent_rest;

    // Handshake: valid/ready both high at an edge transfers one word; ready
    // is registered and reflects room for the count after that edge.
    assign w_din  = {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
    assign w_push = s_axis_tvalid && r_tready && !w_full;

    axis_word_fifo #(
        .WIDTH      (ENTRY_W),
        .DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_fifo (
        .i_clk   (aclk),
        .i_rst_n (aresetn),
        .i_push  (w_push),
        .i_din   (w_din),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_lane_done  = (r_state == SHIFT) && (r_slot == '0) && (r_lane == 2'd3);
        w_advance    = (r_state == SHIFT) && (r_slot == '0) && (r_lane != 2'd3);
        w_pop        = !w_empty && ((r_state == IDLE) || w_lane_done);
        w_count_next = w_count + CW'(w_push) - CW'(w_pop);
    end

    always_comb begin
        w_state_next      = r_state;
        w_shift_next      = r_shift;
        w_keep_next       = r_keep;
        w_last_next       = r_last;
        w_lane_next       = r_lane;
        w_slot_next       = r_slot;
        w_data_pins_next  = r_data_pins;
        w_pins_valid_next = 1'b0;
        w_frame_end_next  = 1'b0;

        // Lane about to be presented: either the next lane of the held word
        // or lane 0 of a freshly popped head entry.
        w_ent_keep = r_keep;
        w_ent_lane = r_lane + 2'd1;
        w_ent_last = r_last;
        w_ent_byte = r_shift[PIN_W-1:0];
        w_ent_rest = {{PIN_W{1'b0}}, r_shift[AXIS_DATA_W-1:PIN_W]};
        if (w_pop) begin
            w_ent_keep = w_head[ENTRY_KEEP_LSB +: AXIS_KEEP_W];
            w_ent_lane = 2'd0;
            w_ent_last = w_head[ENTRY_LAST_BIT];
            w_ent_byte = w_head[ENTRY_DATA_LSB +: PIN_W];
            w_ent_rest = {{PIN_W{1'b0}}, w_head[ENTRY_DATA_LSB+PIN_W +: AXIS_DATA_W-PIN_W]};
        end

        if (w_pop || w_advance) begin
            w_state_next     = SHIFT;
            w_lane_next      = w_ent_lane;
            w_keep_next      = w_ent_keep;
            w_last_next      = w_ent_last;
            w_shift_next     = w_ent_rest;
            w_frame_end_next = lane_marks_frame_end(w_ent_keep, w_ent_lane, w_ent_last);
            if (w_ent_keep[w_ent_lane]) begin
                w_data_pins_next  = w_ent_byte;
                w_pins_valid_next = 1'b1;
                w_slot_next       = SLOT_RELOAD;
            end else begin
                w_slot_next = '0;
            end
        end else if (r_state == SHIFT) begin
            if (r_slot != '0) w_slot_next = r_slot - 8'd1;
            else              w_state_next = IDLE;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state      <= IDLE;
            r_shift      <= '0;
            r_keep       <= '0;
            r_last       <= 1'b0;
            r_lane       <= '0;
            r_slot       <= '0;
            r_data_pins  <= '0;
            r_pins_valid <= 1'b0;
            r_frame_end  <= 1'b0;
            r_tready     <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_shift      <= w_shift_next;
            r_keep       <= w_keep_next;
            r_last       <= w_last_next;
            r_lane       <= w_lane_next;
            r_slot       <= w_slot_next;
            r_data_pins  <= w_data_pins_next;
            r_pins_valid <= w_pins_valid_next;
            r_frame_end  <= w_frame_end_next;
            r_tready     <= (w_count_next != FULL_COUNT);
        end
    end

`ifdef AXIS_PIN_SINK_UNDERRUN_CNT_EN
    logic [15:0] r_underrun_count;

    // Starvation: lane 3 finished, nothing buffered, and the frame is still open.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_underrun_count <= '0;
        end else if (w_lane_done && w_empty && !r_last && (r_underrun_count != 16'hFFFF)) begin
            r_underrun_count <= r_underrun_count + 16'd1;
        end
    end

    assign underrun_count = r_underrun_count;
`endif

    assign s_axis_tready = r_tready;
    assign data_pins     = r_data_pins;
    assign pins_valid    = r_pins_valid;
    assign frame_end     = r_frame_end;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_axi_stream_pin_sink.sv
// Directed bench for axi_stream_pin_sink: three instances (CLK_DIV 1, 3, 4)
// share clock and reset; each scenario task checks its outputs inline.
module tb_axi_stream_pin_sink;
    import axis_pin_pkg::*;

    logic        aclk;
    logic        aresetn;
    logic        tvalid     [3];
    logic        tready     [3];
    logic [31:0] tdata      [3];
    logic [3:0]  tkeep      [3];
    logic        tlast      [3];
    logic [7:0]  data_pins  [3];
    logic        pins_valid [3];
    logic        frame_end  [3];
    ser_state_e  dbg        [3];
`ifdef AXIS_PIN_SINK_UNDERRUN_CNT_EN
    logic [15:0] underrun   [3];
`endif

    int checks;
    int errors;
    logic [7:0] exp_q[$];

    // ---------------- clock / reset ----------------
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    for (genvar g = 0; g < 3; g++) begin : g_dut
        axi_stream_pin_sink #(
            .FIFO_DEPTH_BITS (4),
            .CLK_DIV         ((g == 0) ? 1 : ((g == 1) ? 3 : 4))
        ) u_dut (
            .aclk          (aclk),
            .aresetn       (aresetn),
            .s_axis_tvalid (tvalid[g]),
            .s_axis_tready (tready[g]),
            .s_axis_tdata  (tdata[g]),
            .s_axis_tkeep  (tkeep[g]),
            .s_axis_tlast  (tlast[g]),
            .data_pins     (data_pins[g]),
            .pins_valid    (pins_valid[g]),
            .frame_end     (frame_end[g]),
`ifdef AXIS_PIN_SINK_UNDERRUN_CNT_EN
            .underrun_count(underrun[g]),
`endif
            .o_dbg_state   (dbg[g])
        );
    end

    // ---------------- driver ----------------
    // Called just after a negedge; returns just after the negedge that
    // follows the accepting posedge.
    task automatic send_word(input int idx, input logic [31:0] d, input logic [3:0] k, input logic l);
        int guard;
        guard = 0;
        tdata[idx]  = d;
        tkeep[idx]  = k;
        tlast[idx]  = l;
        tvalid[idx] = 1'b1;
        while (tready[idx] !== 1'b1 && guard < 50) begin
            @(negedge aclk);
            guard++;
        end
        checks++;
        if (guard >= 50) begin
            errors++;
            $display("FAIL send_handshake idx=%0d tready=%b required 1", idx, tready[idx]);
        end
        @(negedge aclk);
        tvalid[idx] = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tvalid[i] = 1'b0;
            tdata[i]  = '0;
            tkeep[i]  = '0;
            tlast[i]  = 1'b0;
        end
        aresetn = 1'b1;
        #1 aresetn = 1'b0;
        @(negedge aclk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (tready[i] !== 1'b0 || data_pins[i] !== 8'h00 || pins_valid[i] !== 1'b0 ||
                frame_end[i] !== 1'b0 || dbg[i] !== IDLE) begin
                errors++;
                $display("FAIL reset_values idx=%0d tready=%b pins=%h pv=%b fe=%b st=%0d required 0 00 0 0 0",
                         i, tready[i], data_pins[i], pins_valid[i], frame_end[i], dbg[i]);
            end
`ifdef AXIS_PIN_SINK_UNDERRUN_CNT_EN
            checks++;
            if (underrun[i] !== 16'h0000) begin
                errors++;
                $display("FAIL reset_underrun idx=%0d got %h required 0000", i, underrun[i]);
            end
`endif
        end
        aresetn = 1'b1;
        @(negedge aclk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (tready[i] !== 1'b1) begin
                errors++;
                $display("FAIL ready_after_release idx=%0d got %b required 1", i, tready[i]);
            end
        end
    endtask

    task automatic test_single_word();
        logic [7:0] exp_d [4];
        exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_word(0, 32'h44332211, 4'b1111, 1'b1);
        checks++;
        if (pins_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL single_latency pv=%b required 0", pins_valid[0]);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            checks++;
            if (data_pins[0] !== exp_d[i] || pins_valid[0] !== 1'b1 || frame_end[0] !== (i == 3)) begin
                errors++;
                $display("FAIL single_byte%0d pins=%h pv=%b fe=%b required %h 1 %b",
                         i, data_pins[0], pins_valid[0], frame_end[0], exp_d[i], (i == 3));
            end
        end
        @(negedge aclk);
        checks++;
        if (pins_valid[0] !== 1'b0 || frame_end[0] !== 1'b0 || dbg[0] !== IDLE) begin
            errors++;
            $display("FAIL single_idle pv=%b fe=%b st=%0d required 0 0 0", pins_valid[0], frame_end[0], dbg[0]);
        end
    endtask

    task automatic test_frame_end_partial();
        logic [7:0] exp_d  [5];
        logic       exp_pv [5];
        logic       exp_fe [5];
        exp_d  = '{8'h01, 8'h02, 8'h03, 8'h03, 8'h03};
        exp_pv = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_fe = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        send_word(0, 32'h04030201, 4'b0111, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            checks++;
            if (data_pins[0] !== exp_d[i] || pins_valid[0] !== exp_pv[i] || frame_end[0] !== exp_fe[i]) begin
                errors++;
                $display("FAIL partial_cycle%0d pins=%h pv=%b fe=%b required %h %b %b",
                         i, data_pins[0], pins_valid[0], frame_end[0], exp_d[i], exp_pv[i], exp_fe[i]);
            end
        end
    endtask

    task automatic test_sparse_keep();
        logic [7:0] exp_d  [8];
        logic       exp_pv [8];
        logic       exp_fe [8];
        exp_d  = '{8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hCC, 8'hCC, 8'hCC, 8'hCC};
        exp_pv = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_fe = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        send_word(1, 32'hDDCCBBAA, 4'b0101, 1'b1);
        checks++;
        if (pins_valid[1] !== 1'b0) begin
            errors++;
            $display("FAIL sparse_latency pv=%b required 0", pins_valid[1]);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge aclk);
            checks++;
            if (data_pins[1] !== exp_d[i] || pins_valid[1] !== exp_pv[i] || frame_end[1] !== exp_fe[i]) begin
                errors++;
                $display("FAIL sparse_cycle%0d pins=%h pv=%b fe=%b required %h %b %b",
                         i, data_pins[1], pins_valid[1], frame_end[1], exp_d[i], exp_pv[i], exp_fe[i]);
            end
        end
        @(negedge aclk);
        checks++;
        if (dbg[1] !== IDLE || pins_valid[1] !== 1'b0) begin
            errors++;
            $display("FAIL sparse_idle st=%0d pv=%b required 0 0", dbg[1], pins_valid[1]);
        end
    endtask

    task automatic test_back_to_back();
        int   sent;
        int   bytes;
        int   last_cyc;
        logic acc;
        logic saw_full;
        logic [7:0] exp_b;
        exp_q.delete();
        sent = 0; bytes = 0; last_cyc = 0; acc = 1'b0; saw_full = 1'b0;
        for (int cyc = 0; cyc < 400 && bytes < 80; cyc++) begin
            @(negedge aclk);
            if (acc) begin
                for (int b = 0; b < 4; b++) exp_q.push_back(8'(4 * sent + b));
                sent++;
            end
            if (pins_valid[2] === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra_byte got %h required none", data_pins[2]);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (data_pins[2] !== exp_b) begin
                        errors++;
                        $display("FAIL b2b_byte%0d got %h required %h", bytes, data_pins[2], exp_b);
                    end
                end
                if (bytes > 0) begin
                    checks++;
                    if (cyc - last_cyc != 4) begin
                        errors++;
                        $display("FAIL b2b_spacing byte%0d got %0d cycles required 4", bytes, cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
                bytes++;
            end
            if (!saw_full && sent < 20 && tvalid[2] && tready[2] !== 1'b1) begin
                saw_full = 1'b1;
                checks++;
                if (sent - (bytes + 3) / 4 != 16) begin
                    errors++;
                    $display("FAIL b2b_full_level got %0d words buffered required 16", sent - (bytes + 3) / 4);
                end
            end
            if (sent < 20) begin
                tdata[2]  = {8'(4 * sent + 3), 8'(4 * sent + 2), 8'(4 * sent + 1), 8'(4 * sent)};
                tkeep[2]  = 4'b1111;
                tlast[2]  = (sent == 19);
                tvalid[2] = 1'b1;
            end else begin
                tvalid[2] = 1'b0;
            end
            acc = tvalid[2] && (tready[2] === 1'b1);
        end
        tvalid[2] = 1'b0;
        checks++;
        if (sent != 20 || bytes != 80 || exp_q.size() != 0 || !saw_full) begin
            errors++;
            $display("FAIL b2b_totals sent=%0d bytes=%0d left=%0d full_seen=%b required 20 80 0 1",
                     sent, bytes, exp_q.size(), saw_full);
        end
    endtask

    task automatic test_reset_mid_word();
        int got;
        logic [7:0] exp_b;
        send_word(1, 32'h99887766, 4'b1111, 1'b1);
        send_word(1, 32'h55555555, 4'b1111, 1'b1);
        repeat (7) @(negedge aclk);
        checks++;
        if (data_pins[1] !== 8'h88 || pins_valid[1] !== 1'b0) begin
            errors++;
            $display("FAIL midreset_setup pins=%h pv=%b required 88 0", data_pins[1], pins_valid[1]);
        end
        #2 aresetn = 1'b0;
        #1;
        checks++;
        if (tready[1] !== 1'b0 || data_pins[1] !== 8'h00 || pins_valid[1] !== 1'b0 ||
            frame_end[1] !== 1'b0 || dbg[1] !== IDLE) begin
            errors++;
            $display("FAIL midreset_async tready=%b pins=%h pv=%b fe=%b st=%0d required 0 00 0 0 0",
                     tready[1], data_pins[1], pins_valid[1], frame_end[1], dbg[1]);
        end
        @(negedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        checks++;
        if (tready[1] !== 1'b1) begin
            errors++;
            $display("FAIL midreset_ready got %b required 1", tready[1]);
        end
        exp_q.delete();
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hEE);
        send_word(1, 32'h0000EEFF, 4'b0011, 1'b1);
        checks++;
        if (data_pins[1] !== 8'h00 || pins_valid[1] !== 1'b0) begin
            errors++;
            $display("FAIL midreset_stale pins=%h pv=%b required 00 0", data_pins[1], pins_valid[1]);
        end
        got = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge aclk);
            if (pins_valid[1] === 1'b1) begin
                checks++;
                got++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL midreset_extra got %h required none", data_pins[1]);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (data_pins[1] !== exp_b) begin
                        errors++;
                        $display("FAIL midreset_byte got %h required %h", data_pins[1], exp_b);
                    end
                end
            end
        end
        checks++;
        if (got != 2) begin
            errors++;
            $display("FAIL midreset_count got %0d bytes required 2", got);
        end
    endtask

`ifdef AXIS_PIN_SINK_UNDERRUN_CNT_EN
    task automatic test_underrun();
        logic [15:0] exp_u [3];
        logic        lasts [3];
        exp_u = '{16'd1, 16'd2, 16'd2};
        lasts = '{1'b0, 1'b0, 1'b1};
        checks++;
        if (underrun[0] !== 16'd0) begin
            errors++;
            $display("FAIL underrun_start got %0d required 0", underrun[0]);
        end
        for (int w = 0; w < 3; w++) begin
            send_word(0, 32'hA5A50000 + 32'(w), 4'b1111, lasts[w]);
            repeat (20) @(negedge aclk);
            checks++;
            if (underrun[0] !== exp_u[w]) begin
                errors++;
                $display("FAIL underrun_word%0d got %0d required %0d", w, underrun[0], exp_u[w]);
            end
        end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_word();
        test_frame_end_partial();
        test_sparse_keep();
        test_back_to_back();
        test_reset_mid_word();
`ifdef AXIS_PIN_SINK_UNDERRUN_CNT_EN
        test_underrun();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
